// File: rtl/mem64_wb_reader_pkg.sv
// Shared types and constants for the 64-bit capture-memory Wishbone reader.
package mem64_wb_reader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_HI,
    AK_HI,
    RD_LO,
    AK_LO,
    PUSH,
    FIN
  } state_t;

  localparam logic [3:0]  C_WB_SEL_ALL = 4'hF;
  localparam int unsigned C_TMO_W      = 16;

endpackage

// File: rtl/mem64_wb_reader.sv
// Wishbone pipelined initiator: reads N 64-bit entries as hi/lo 32-bit word pairs
// and streams the reassembled entries out on a valid/ready interface.
module mem64_wb_reader
  import mem64_wb_reader_pkg::*;
#(
  parameter int unsigned g_addr_width = 6,
  parameter int unsigned g_timeout    = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    start_i,
  input  logic [g_addr_width-1:0] base_i,
  input  logic [g_addr_width:0]   count_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic [g_addr_width:0]   wb_adr_o,
  output logic [3:0]              wb_sel_o,
  output logic                    wb_we_o,
  output logic [31:0]             wb_dat_o,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i,
  input  logic                    wb_rty_i,
  input  logic                    wb_stall_i,
  input  logic [31:0]             wb_dat_i,
  output logic [63:0]             dout_o,
  output logic [g_addr_width-1:0] dout_idx_o,
  output logic                    dout_valid_o,
  input  logic                    dout_ready_i
);

  localparam int unsigned AW = g_addr_width;
  localparam int unsigned CW = g_addr_width + 1;
  localparam logic [C_TMO_W-1:0] TMO_LAST = C_TMO_W'(g_timeout - 1);

  state_t               state_q, state_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic [CW-1:0]        rem_q, rem_d;
  logic [C_TMO_W-1:0]   tmo_q, tmo_d;
  logic [31:0]          hi_q, hi_d;
  logic [31:0]          lo_q, lo_d;
  logic                 err_q, err_d;
  logic                 cyc_q, cyc_d;
  logic                 stb_q, stb_d;
  logic [CW-1:0]        adr_q, adr_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic rd_st, ak_st, lo_half, live, tmo_hit;

  // State, datapath and registered outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      tmo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      err_q   <= 1'b0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      adr_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      tmo_q   <= tmo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      adr_q   <= adr_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state; outputs are decoded from the next state so they register in step
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    tmo_d   = tmo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    err_d   = err_q;

    rd_st   = (state_q == RD_HI) || (state_q == RD_LO);
    ak_st   = (state_q == AK_HI) || (state_q == AK_LO);
    lo_half = (state_q == RD_LO) || (state_q == AK_LO);
    // A request is outstanding when waiting, or when the strobe is taken this cycle
    live    = ak_st || (rd_st && !wb_stall_i);
    tmo_hit = ak_st && (tmo_q == TMO_LAST);

    case (state_q)
      IDLE: begin
        if (start_i) begin
          err_d = 1'b0;
          if (count_i == '0) begin
            state_d = FIN;
          end else begin
            idx_d   = base_i;
            rem_d   = count_i;
            state_d = RD_HI;
          end
        end
      end
      RD_HI, AK_HI, RD_LO, AK_LO: begin
        if (live) begin
          tmo_d = rd_st ? '0 : tmo_q + C_TMO_W'(1);
          if (wb_err_i || wb_rty_i || tmo_hit) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else if (wb_ack_i) begin
            if (lo_half) begin
              lo_d    = wb_dat_i;
              state_d = PUSH;
            end else begin
              hi_d    = wb_dat_i;
              state_d = RD_LO;
            end
          end else if (rd_st) begin
            state_d = lo_half ? AK_LO : AK_HI;
          end
        end
      end
      PUSH: begin
        if (dout_ready_i) begin
          rem_d   = rem_q - CW'(1);
          idx_d   = idx_q + AW'(1);
          state_d = (rem_q == CW'(1)) ? FIN : RD_HI;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cyc_d   = (state_d == RD_HI) || (state_d == AK_HI) ||
              (state_d == RD_LO) || (state_d == AK_LO);
    stb_d   = (state_d == RD_HI) || (state_d == RD_LO);
    adr_d   = {idx_d, (state_d == RD_LO) || (state_d == AK_LO)};
    valid_d = (state_d == PUSH);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == FIN);
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign wb_cyc_o     = cyc_q;
  assign wb_stb_o     = stb_q;
  assign wb_adr_o     = adr_q;
  assign wb_sel_o     = C_WB_SEL_ALL;
  assign wb_we_o      = 1'b0;
  assign wb_dat_o     = '0;
  assign dout_o       = {hi_q, lo_q};
  assign dout_idx_o   = idx_q;
  assign dout_valid_o = valid_q;

endmodule

// File: tb/tb_mem64_wb_reader.sv
// Self-checking bench for mem64_wb_reader: Wishbone slave model, stream consumer,
// and an entry-level reference model of which words and entries a transfer yields.
module tb_mem64_wb_reader;

  localparam int unsigned AW   = 6;
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned TMO  = 8;
  localparam int          NENT = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i;
  logic [AW-1:0] base_i;
  logic [CW-1:0] count_i;
  logic          busy_o, done_o, err_o;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [CW-1:0] wb_adr_o;
  logic [3:0]    wb_sel_o;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i;
  logic [31:0]   wb_dat_i;
  logic [63:0]   dout_o;
  logic [AW-1:0] dout_idx_o;
  logic          dout_valid_o, dout_ready_i;

  always #5 clk = ~clk;

  mem64_wb_reader #(.g_addr_width(AW), .g_timeout(TMO)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_i), .base_i(base_i), .count_i(count_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_dat_o(wb_dat_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_rty_i(wb_rty_i), .wb_stall_i(wb_stall_i), .wb_dat_i(wb_dat_i),
    .dout_o(dout_o), .dout_idx_o(dout_idx_o), .dout_valid_o(dout_valid_o),
    .dout_ready_i(dout_ready_i)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [31:0] mem [0:2*NENT-1];

  // Slave / consumer configuration and logs
  int ack_lat = 1;
  int stall_left = 0;
  int err_adr = -1;
  bit no_ack = 1'b0;
  bit pend = 1'b0;
  int pend_cnt = 0;
  int pend_adr = 0;
  bit stalled_prev = 1'b0;
  int stall_adr = 0;
  int overlap_err = 0;
  int acc_q[$];
  int bp = 0;
  int bp_cnt = 0;
  bit hold_prev = 1'b0;
  logic [63:0] hold_dat;
  int hold_idx;
  logic [63:0] got_dat[$];
  int got_idx[$];
  int done_cnt = 0;
  int ak_cycles = 0;
  int cyc_cycles = 0;

  // Expected transfer contents
  int exp_adr[$];
  int exp_idx[$];
  logic [63:0] exp_dat[$];

  // Bus slave, stream consumer and activity monitor, all acting 1 time unit after the edge
  initial begin
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_stall_i = 1'b0;
    wb_dat_i = '0; dout_ready_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_stall_i = 1'b0;
      wb_dat_i = $urandom; dout_ready_i = 1'b0;
      if (!rst_n) begin
        pend = 1'b0; stalled_prev = 1'b0; hold_prev = 1'b0; bp_cnt = 0;
        continue;
      end
      if (stalled_prev) begin
        vectors++;
        if (!(wb_cyc_o && wb_stb_o) || int'(wb_adr_o) != stall_adr) begin
          miscompares++;
          $display("FAIL stall_hold: stb=%0b adr=%0d, expected stb=1 adr=%0d",
                   wb_stb_o, wb_adr_o, stall_adr);
        end
        stalled_prev = 1'b0;
      end
      if (wb_cyc_o && wb_stb_o) begin
        if (pend) overlap_err++;
        if (stall_left > 0) begin
          wb_stall_i = 1'b1; stall_left--; stalled_prev = 1'b1; stall_adr = int'(wb_adr_o);
        end else begin
          acc_q.push_back(int'(wb_adr_o));
          pend = 1'b1; pend_cnt = ack_lat; pend_adr = int'(wb_adr_o);
        end
      end
      if (pend) begin
        if (pend_cnt == 0) begin
          pend = 1'b0;
          if (!no_ack) begin
            if (pend_adr == err_adr) begin
              wb_err_i = 1'b1;
              wb_ack_i = 1'($urandom_range(0, 1));
            end else begin
              wb_ack_i = 1'b1;
              wb_dat_i = mem[pend_adr];
            end
          end
        end else begin
          pend_cnt--;
        end
      end
      if (wb_cyc_o) cyc_cycles++;
      if (wb_cyc_o && !wb_stb_o) ak_cycles++;
      if (done_o) done_cnt++;
      if (dout_valid_o) begin
        if (hold_prev) begin
          vectors++;
          if (dout_o !== hold_dat || int'(dout_idx_o) != hold_idx) begin
            miscompares++;
            $display("FAIL dout_stable: dout=%h idx=%0d, expected dout=%h idx=%0d",
                     dout_o, dout_idx_o, hold_dat, hold_idx);
          end
        end
        if (bp_cnt < bp) begin
          bp_cnt++; hold_prev = 1'b1; hold_dat = dout_o; hold_idx = int'(dout_idx_o);
        end else begin
          dout_ready_i = 1'b1;
          got_dat.push_back(dout_o); got_idx.push_back(int'(dout_idx_o));
          bp_cnt = 0; hold_prev = 1'b0;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: entry k comes from index (base+k) mod 64, hi word at 2*idx, lo at 2*idx+1
  task automatic build_expected(input int b, input int c);
    exp_adr.delete(); exp_idx.delete(); exp_dat.delete();
    for (int k = 0; k < c; k++) begin
      int idx;
      idx = (b + k) % NENT;
      exp_adr.push_back(2 * idx);
      exp_adr.push_back(2 * idx + 1);
      exp_idx.push_back(idx);
      exp_dat.push_back({mem[2*idx], mem[2*idx+1]});
    end
  endtask

  task automatic clear_logs();
    acc_q.delete(); got_dat.delete(); got_idx.delete();
    done_cnt = 0; ak_cycles = 0; cyc_cycles = 0; overlap_err = 0;
  endtask

  task automatic config_slave(input int lat, input int bpv, input int stall, input int eadr);
    ack_lat = lat; bp = bpv; stall_left = stall; err_adr = eadr; no_ack = 1'b0;
  endtask

  task automatic start_xfer(input int b, input int c);
    @(posedge clk); #2;
    start_i = 1'b1; base_i = AW'(b); count_i = CW'(c);
    @(posedge clk); #2;
    start_i = 1'b0;
  endtask

  // Waits (bounded) for the done pulse, then one more cycle
  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (done_o) begin ok = 1'b1; break; end
      @(posedge clk); #2;
    end
    @(posedge clk); #2;
  endtask

  task automatic test_reset();
    @(posedge clk); #2;
    vectors++;
    if ({wb_cyc_o, wb_stb_o, dout_valid_o, busy_o, done_o, err_o} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: cyc/stb/valid/busy/done/err=%b, expected 000000",
               {wb_cyc_o, wb_stb_o, dout_valid_o, busy_o, done_o, err_o});
    end
    vectors++;
    if (wb_adr_o !== '0 || dout_o !== '0 || dout_idx_o !== '0) begin
      miscompares++;
      $display("FAIL reset_data: adr=%0d dout=%h idx=%0d, expected 0 0 0", wb_adr_o, dout_o, dout_idx_o);
    end
    vectors++;
    if (wb_sel_o !== 4'hF || wb_we_o !== 1'b0 || wb_dat_o !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_const: sel=%h we=%b dat=%h, expected F 0 0", wb_sel_o, wb_we_o, wb_dat_o);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_normal();
    bit ok;
    mem[10] = 32'h11223344; mem[11] = 32'h55667788;
    config_slave(2, 0, 0, -1); clear_logs();
    start_xfer(5, 1); wait_done(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL normal_done: no done pulse, expected one"); end
    vectors++;
    if (acc_q.size() != 2 || acc_q[0] != 10 || acc_q[1] != 11) begin
      miscompares++;
      $display("FAIL normal_adr: %0d requests first=%0d, expected 2 requests 10,11", acc_q.size(), acc_q[0]);
    end
    vectors++;
    if (got_dat.size() != 1 || got_dat[0] !== 64'h1122334455667788 || got_idx[0] != 5) begin
      miscompares++;
      $display("FAIL normal_data: n=%0d dout=%h idx=%0d, expected 1 1122334455667788 5",
               got_dat.size(), got_dat[0], got_idx[0]);
    end
    vectors++;
    if (done_cnt != 1 || err_o !== 1'b0 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL normal_status: done=%0d err=%b busy=%b, expected 1 0 0", done_cnt, err_o, busy_o);
    end
  endtask

  // Generic transfer with inline comparisons against the reference model
  task automatic test_transfer(input int b, input int c, input int lat, input int bpv, input int stall);
    bit ok;
    config_slave(lat, bpv, stall, -1); clear_logs();
    build_expected(b, c);
    start_xfer(b, c); wait_done(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL xfer_done: base=%0d count=%0d no done", b, c); end
    vectors++;
    if (acc_q.size() != exp_adr.size()) begin
      miscompares++;
      $display("FAIL xfer_nreq: %0d requests, expected %0d", acc_q.size(), exp_adr.size());
    end
    for (int i = 0; i < exp_adr.size() && i < acc_q.size(); i++) begin
      vectors++;
      if (acc_q[i] != exp_adr[i]) begin
        miscompares++;
        $display("FAIL xfer_adr[%0d]: %0d, expected %0d", i, acc_q[i], exp_adr[i]);
      end
    end
    vectors++;
    if (got_dat.size() != exp_dat.size()) begin
      miscompares++;
      $display("FAIL xfer_nent: %0d entries, expected %0d", got_dat.size(), exp_dat.size());
    end
    for (int i = 0; i < exp_dat.size() && i < got_dat.size(); i++) begin
      vectors++;
      if (got_dat[i] !== exp_dat[i] || got_idx[i] != exp_idx[i]) begin
        miscompares++;
        $display("FAIL xfer_entry[%0d]: %h idx %0d, expected %h idx %0d",
                 i, got_dat[i], got_idx[i], exp_dat[i], exp_idx[i]);
      end
    end
    vectors++;
    if (done_cnt != 1 || err_o !== 1'b0 || overlap_err != 0) begin
      miscompares++;
      $display("FAIL xfer_status: done=%0d err=%b overlap=%0d, expected 1 0 0", done_cnt, err_o, overlap_err);
    end
  endtask

  task automatic test_wrap_backpressure();
    test_transfer(62, 4, 1, 3, 0);
  endtask

  task automatic test_stall();
    test_transfer(int'($urandom_range(0, 63)), 1, 2, 0, 4);
  endtask

  task automatic test_error();
    bit ok;
    int b;
    b = int'($urandom_range(0, 63));
    config_slave(1, 0, 0, 2 * b + 1); clear_logs();
    start_xfer(b, 3); wait_done(ok);
    vectors++;
    if (!ok || done_cnt != 1) begin
      miscompares++;
      $display("FAIL error_done: done pulses=%0d, expected 1", done_cnt);
    end
    vectors++;
    if (got_dat.size() != 0 || err_o !== 1'b1 || wb_cyc_o !== 1'b0) begin
      miscompares++;
      $display("FAIL error_status: entries=%0d err=%b cyc=%b, expected 0 1 0", got_dat.size(), err_o, wb_cyc_o);
    end
    vectors++;
    if (acc_q.size() != 2) begin
      miscompares++;
      $display("FAIL error_nreq: %0d requests, expected 2", acc_q.size());
    end
    config_slave(1, 0, 0, -1); clear_logs();
    start_xfer(b, 1);
    vectors++;
    if (err_o !== 1'b0 || busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL error_clear: err=%b busy=%b after start, expected 0 1", err_o, busy_o);
    end
    wait_done(ok);
    vectors++;
    if (got_dat.size() != 1 || got_dat[0] !== {mem[2*b], mem[2*b+1]}) begin
      miscompares++;
      $display("FAIL error_recover: n=%0d dout=%h, expected 1 %h", got_dat.size(), got_dat[0], {mem[2*b], mem[2*b+1]});
    end
  endtask

  task automatic test_timeout();
    bit ok;
    config_slave(0, 0, 0, -1); no_ack = 1'b1; clear_logs();
    start_xfer(int'($urandom_range(0, 63)), 2); wait_done(ok);
    no_ack = 1'b0;
    vectors++;
    if (!ok || err_o !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_err: done=%b err=%b, expected 1 1", ok, err_o);
    end
    vectors++;
    if (ak_cycles != int'(TMO)) begin
      miscompares++;
      $display("FAIL timeout_len: %0d wait cycles, expected %0d", ak_cycles, TMO);
    end
    vectors++;
    if (got_dat.size() != 0 || acc_q.size() != 1) begin
      miscompares++;
      $display("FAIL timeout_bus: entries=%0d requests=%0d, expected 0 1", got_dat.size(), acc_q.size());
    end
  endtask

  task automatic test_count_zero();
    clear_logs();
    start_xfer(int'($urandom_range(0, 63)), 0);
    vectors++;
    if (done_o !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_done: done=%b one cycle after start, expected 1", done_o);
    end
    @(posedge clk); #2;
    vectors++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_end: done=%b busy=%b, expected 0 0", done_o, busy_o);
    end
    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (cyc_cycles != 0 || acc_q.size() != 0) begin
      miscompares++;
      $display("FAIL zero_bus: cyc cycles=%0d requests=%0d, expected 0 0", cyc_cycles, acc_q.size());
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int b, c;
      b = int'($urandom_range(0, 63));
      c = (r == 0) ? NENT : int'($urandom_range(1, 6));
      test_transfer(b, c, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    config_slave(6, 0, 0, -1); clear_logs();
    start_xfer(int'($urandom_range(0, 63)), 3);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (wb_cyc_o && !wb_stb_o && wb_adr_o[0]) begin found = 1'b1; break; end
      @(posedge clk); #2;
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL rstmid_reach: lo-word wait never seen, expected it"); end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({wb_cyc_o, wb_stb_o, dout_valid_o, busy_o, done_o, err_o} !== 6'b0 || wb_adr_o !== '0) begin
      miscompares++;
      $display("FAIL rstmid_async: cyc/stb/valid/busy/done/err=%b adr=%0d, expected 000000 0",
               {wb_cyc_o, wb_stb_o, dout_valid_o, busy_o, done_o, err_o}, wb_adr_o);
    end
    @(negedge clk); rst_n = 1'b1;
    clear_logs();
    repeat (12) @(posedge clk);
    #2;
    vectors++;
    if (cyc_cycles != 0 || got_dat.size() != 0 || dout_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_after: cyc cycles=%0d entries=%0d valid=%b, expected 0 0 0",
               cyc_cycles, got_dat.size(), dout_valid_o);
    end
  endtask

  initial begin
    start_i = 1'b0; base_i = '0; count_i = '0;
    for (int i = 0; i < 2 * NENT; i++) mem[i] = $urandom;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    test_normal();
    test_wrap_backpressure();
    test_stall();
    test_error();
    test_timeout();
    test_count_zero();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
